// File: rtl/coherence_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coherence_bus_ctrl
// Purpose  : NCPU-way memory/coherence controller. Round-robin arbitrates the
//            per-core I-fetch and D-block traffic onto one RAM port and runs
//            an MSI snoop bus (broadcast snoop, cache-to-cache transfer with
//            memory update, S->M upgrade invalidation, BLOCK_WORDS bursts).
// Ports    : CLK/nRST          clock, async active-low reset
//            iREN/iaddr        I-fetch request/address per core
//            iwait/iload       I-fetch stall (0 pulse = data valid) / data
//            dREN/dWEN/daddr   D-block fill / writeback request, beat address
//            dstore            writeback or snoop-supplied word per core
//            dwait/dload       D beat stall (0 pulse = beat done) / fill data
//            ccwrite/cctrans   requester BusRdX / state change or M-hit
//            ccwait/ccinv      snoop-response hold / invalidate per core
//            ccsnoopaddr       snoop address per core
//            ramstate/ramload  RAM status (FREE/BUSY/ACCESS/ERROR) / data
//            ramREN/ramWEN     RAM strobes
//            ramaddr/ramstore  RAM address / write data
// Revision : 1.0 - initial release
// ============================================================================
module coherence_bus_ctrl #(
   parameter int NCPU        = 2,
   parameter int BLOCK_WORDS = 2,
   parameter int AW          = 32
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [NCPU-1:0]          iREN,
   input  logic [NCPU-1:0][AW-1:0]  iaddr,
   output logic [NCPU-1:0]          iwait,
   output logic [NCPU-1:0][AW-1:0]  iload,
   input  logic [NCPU-1:0]          dREN,
   input  logic [NCPU-1:0]          dWEN,
   input  logic [NCPU-1:0][AW-1:0]  daddr,
   input  logic [NCPU-1:0][AW-1:0]  dstore,
   output logic [NCPU-1:0]          dwait,
   output logic [NCPU-1:0][AW-1:0]  dload,
   input  logic [NCPU-1:0]          ccwrite,
   input  logic [NCPU-1:0]          cctrans,
   output logic [NCPU-1:0]          ccwait,
   output logic [NCPU-1:0]          ccinv,
   output logic [NCPU-1:0][AW-1:0]  ccsnoopaddr,
   input  logic [1:0]               ramstate,
   input  logic [AW-1:0]            ramload,
   output logic                     ramREN,
   output logic                     ramWEN,
   output logic [AW-1:0]            ramaddr,
   output logic [AW-1:0]            ramstore
);

   localparam int             PW         = (NCPU > 1) ? $clog2(NCPU) : 1;
   localparam int             BW         = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam logic [1:0]     RAM_ACCESS = 2'd2;
   localparam logic [BW-1:0]  LAST_BEAT  = BW'(BLOCK_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WB     = 3'd1,
      S_IFETCH = 3'd2,
      S_ARB    = 3'd3,
      S_SNOOP  = 3'd4,
      S_C2C    = 3'd5,
      S_LOAD   = 3'd6
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   req_q, req_d;
   logic [PW-1:0]   src_q, src_d;
   logic [PW-1:0]   d_ptr_q, d_ptr_d;
   logic [PW-1:0]   i_ptr_q, i_ptr_d;
   logic [BW-1:0]   beat_q, beat_d;

   // Round-robin pick: {found, index}. Scanning from the farthest candidate
   // back to ptr+1 lets the nearest requester overwrite the result last.
   function automatic logic [PW:0] rr_pick(input logic [NCPU-1:0] reqs,
                                           input logic [PW-1:0]   ptr);
      logic [PW:0] res;
      int          idx;
      res = '0;
      for (int i = NCPU; i >= 1; i--) begin
         idx = (int'(ptr) + i) % NCPU;
         if (reqs[idx]) res = {1'b1, PW'(idx)};
      end
      return res;
   endfunction

   logic [PW:0] pick_w, pick_r, pick_u, pick_i;
   logic        ram_access, last_beat;

   assign pick_w     = rr_pick(dWEN,    d_ptr_q);
   assign pick_r     = rr_pick(dREN,    d_ptr_q);
   assign pick_u     = rr_pick(cctrans, d_ptr_q);
   assign pick_i     = rr_pick(iREN,    i_ptr_q);
   assign ram_access = (ramstate == RAM_ACCESS);
   assign last_beat  = (beat_q == LAST_BEAT);

   // Lowest-index snooped core (other than the requester) holding the block in M.
   logic          snoop_hit;
   logic [PW-1:0] snoop_src;

   always_comb begin
      snoop_hit = 1'b0;
      snoop_src = '0;
      for (int k = NCPU - 1; k >= 0; k--) begin
         if (cctrans[k] && (PW'(k) != req_q)) begin
            snoop_hit = 1'b1;
            snoop_src = PW'(k);
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         req_q   <= '0;
         src_q   <= '0;
         beat_q  <= '0;
         d_ptr_q <= PW'(NCPU - 1);
         i_ptr_q <= PW'(NCPU - 1);
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         src_q   <= src_d;
         beat_q  <= beat_d;
         d_ptr_q <= d_ptr_d;
         i_ptr_q <= i_ptr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      src_d       = src_q;
      beat_d      = beat_q;
      d_ptr_d     = d_ptr_q;
      i_ptr_d     = i_ptr_q;
      iwait       = '1;
      iload       = '0;
      dwait       = '1;
      dload       = '0;
      ccwait      = '0;
      ccinv       = '0;
      ccsnoopaddr = '0;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;

      // Snooped cores stay parked for the whole snoop/transfer phase.
      if (state_q == S_SNOOP || state_q == S_C2C || state_q == S_LOAD) begin
         for (int k = 0; k < NCPU; k++) begin
            if (PW'(k) != req_q) begin
               ccwait[k]      = 1'b1;
               ccsnoopaddr[k] = daddr[req_q];
               ccinv[k]       = ccwrite[req_q];
            end
         end
      end

      case (state_q)
         S_IDLE: begin
            beat_d = '0;
            if (|dWEN) begin
               req_d   = pick_w[PW-1:0];
               state_d = S_WB;
            end else if (|(dREN | cctrans)) begin
               state_d = S_ARB;
            end else if (|iREN) begin
               req_d   = pick_i[PW-1:0];
               state_d = S_IFETCH;
            end
         end

         S_WB: begin
            ramWEN   = 1'b1;
            ramaddr  = daddr[req_q];
            ramstore = dstore[req_q];
            if (ram_access) begin
               dwait[req_q] = 1'b0;
               beat_d       = beat_q + 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  d_ptr_d = req_q;
                  state_d = S_IDLE;
               end
            end
         end

         S_IFETCH: begin
            ramREN       = 1'b1;
            ramaddr      = iaddr[req_q];
            iload[req_q] = ramload;
            if (ram_access) begin
               iwait[req_q] = 1'b0;
               i_ptr_d      = req_q;
               state_d      = S_IDLE;
            end
         end

         S_ARB: begin
            state_d = S_IDLE;
            if (pick_r[PW]) begin
               req_d   = pick_r[PW-1:0];
               state_d = S_SNOOP;
               for (int k = 0; k < NCPU; k++)
                  if (PW'(k) != pick_r[PW-1:0]) ccwait[k] = 1'b1;
            end else if (pick_u[PW]) begin
               // S->M upgrade hit: invalidate the sharers and complete at once.
               for (int k = 0; k < NCPU; k++) begin
                  if (PW'(k) != pick_u[PW-1:0]) begin
                     ccinv[k]       = 1'b1;
                     ccsnoopaddr[k] = daddr[pick_u[PW-1:0]];
                  end
               end
               dwait[pick_u[PW-1:0]] = 1'b0;
               d_ptr_d               = pick_u[PW-1:0];
            end
         end

         S_SNOOP: begin
            if (snoop_hit) begin
               src_d   = snoop_src;
               state_d = S_C2C;
            end else begin
               state_d = S_LOAD;
            end
         end

         S_C2C: begin
            // The M owner supplies the data; memory is updated in the same beat.
            dload[req_q] = dstore[src_q];
            ramWEN       = 1'b1;
            ramaddr      = daddr[req_q];
            ramstore     = dstore[src_q];
            if (ram_access) begin
               dwait[req_q] = 1'b0;
               dwait[src_q] = 1'b0;
               beat_d       = beat_q + 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  d_ptr_d = req_q;
                  state_d = S_IDLE;
               end
            end
         end

         S_LOAD: begin
            ramREN       = 1'b1;
            ramaddr      = daddr[req_q];
            dload[req_q] = ramload;
            if (ram_access) begin
               dwait[req_q] = 1'b0;
               beat_d       = beat_q + 1'b1;
               if (last_beat) begin
                  beat_d  = '0;
                  d_ptr_d = req_q;
                  state_d = S_IDLE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            beat_d  = '0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_coherence_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_coherence_bus_ctrl
// Purpose  : Directed self-checking bench for coherence_bus_ctrl (NCPU=4,
//            BLOCK_WORDS=2). A small RAM model answers every strobe with two
//            BUSY cycles followed by one ACCESS cycle; read data is the
//            address XOR 0xA5A50000.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coherence_bus_ctrl;

   localparam int NC = 4;

   logic                 CLK = 1'b0;
   logic                 nRST;
   logic [NC-1:0]        iREN, dREN, dWEN, ccwrite, cctrans;
   logic [NC-1:0][31:0]  iaddr, daddr, dstore;
   logic [NC-1:0]        iwait, dwait, ccwait, ccinv;
   logic [NC-1:0][31:0]  iload, dload, ccsnoopaddr;
   logic [1:0]           ramstate;
   logic [31:0]          ramload, ramaddr, ramstore;
   logic                 ramREN, ramWEN;

   int tests = 0;
   int fails = 0;

   coherence_bus_ctrl #(.NCPU(NC), .BLOCK_WORDS(2), .AW(32)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
      .ccsnoopaddr(ccsnoopaddr),
      .ramstate(ramstate), .ramload(ramload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
   );

   always #5 CLK = ~CLK;

   // RAM model: BUSY, BUSY, ACCESS for every strobed access.
   int ram_cnt;
   always @(posedge CLK or negedge nRST) begin
      if (!nRST)                 ram_cnt <= 0;
      else if (ramREN || ramWEN) ram_cnt <= (ram_cnt == 2) ? 0 : ram_cnt + 1;
      else                       ram_cnt <= 0;
   end
   assign ramstate = (ramREN || ramWEN) ? ((ram_cnt == 2) ? 2'd2 : 2'd1) : 2'd0;
   assign ramload  = ramaddr ^ 32'hA5A5_0000;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Advance until some core sees a wait pulse low (bounded).
   task automatic wait_any(input string tag);
      int n;
      n = 0;
      tick();
      while (((iwait & dwait) == '1) && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_seen"}, 32'((iwait & dwait) != '1), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e4;
      nRST = 1'b0;
      iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
      iaddr = '0; daddr = '0; dstore = '0;

      // ---------------- reset state ----------------
      #12;
      check("rst_iwait",  32'(iwait),  32'hF);
      check("rst_dwait",  32'(dwait),  32'hF);
      check("rst_ccwait", 32'(ccwait), 32'h0);
      check("rst_strobe", 32'({ramREN, ramWEN}), 32'h0);
      @(negedge CLK);
      nRST = 1'b1;

      // ---------------- 1: four-way fetch round-robin ----------------
      for (int k = 0; k < NC; k++) iaddr[k] = 32'(k * 32'h100);
      iREN = 4'hF;
      for (int k = 0; k < NC; k++) begin
         wait_any($sformatf("t1_g%0d", k));
         e4 = ~(4'b0001 << k);
         check($sformatf("t1_iwait%0d", k), 32'(iwait), 32'(e4));
         check($sformatf("t1_iload%0d", k), iload[k], mem(32'(k * 32'h100)));
         iREN[k] = 1'b0;
      end

      // ---------------- 2: writeback beats beat a pending fetch ----------------
      dWEN[1] = 1'b1; daddr[1] = 32'h40; dstore[1] = 32'h1111_0040;
      iREN[2] = 1'b1; iaddr[2] = 32'h200;
      wait_any("t2_b0");
      check("t2_b0_dwait", 32'(dwait), 32'hD);
      check("t2_b0_iwait", 32'(iwait), 32'hF);
      check("t2_b0_wr",    {ramaddr[15:0], 15'd0, ramWEN}, {16'h0040, 15'd0, 1'b1});
      check("t2_b0_store", ramstore, 32'h1111_0040);
      tick();
      daddr[1] = 32'h44; dstore[1] = 32'h1111_0044;
      wait_any("t2_b1");
      check("t2_b1_dwait", 32'(dwait), 32'hD);
      check("t2_b1_addr",  ramaddr, 32'h44);
      check("t2_b1_store", ramstore, 32'h1111_0044);
      dWEN[1] = 1'b0;
      wait_any("t2_if");
      check("t2_if_iwait", 32'(iwait), 32'hB);
      check("t2_if_iload", iload[2], mem(32'h200));
      iREN[2] = 1'b0;

      // ---------------- 3: plain fill from memory ----------------
      dREN[0] = 1'b1; daddr[0] = 32'h80; ccwrite[0] = 1'b0;
      wait_any("t3_b0");
      check("t3_b0_dwait",  32'(dwait),  32'hE);
      check("t3_b0_dload",  dload[0],    mem(32'h80));
      check("t3_b0_ccwait", 32'(ccwait), 32'hE);
      check("t3_b0_ccinv",  32'(ccinv),  32'h0);
      check("t3_b0_snaddr", ccsnoopaddr[3], 32'h80);
      check("t3_b0_ren",    32'({ramREN, ramWEN}), 32'h2);
      tick();
      daddr[0] = 32'h84;
      wait_any("t3_b1");
      check("t3_b1_dload", dload[0], mem(32'h84));
      dREN[0] = 1'b0;
      tick();
      check("t3_idle_ccwait", 32'(ccwait), 32'h0);

      // ---------------- 4: cache-to-cache with BusRdX ----------------
      dREN[2] = 1'b1; ccwrite[2] = 1'b1; daddr[2] = 32'h300;
      cctrans[1] = 1'b1; cctrans[3] = 1'b1;
      dstore[1] = 32'hDEAD_0001; dstore[3] = 32'hBAD0_0003;
      wait_any("t4_b0");
      check("t4_b0_dwait", 32'(dwait), 32'h9);
      check("t4_b0_dload", dload[2], 32'hDEAD_0001);
      check("t4_b0_store", ramstore, 32'hDEAD_0001);
      check("t4_b0_wr",    {ramaddr[15:0], 15'd0, ramWEN}, {16'h0300, 15'd0, 1'b1});
      check("t4_b0_ccinv", 32'(ccinv), 32'hB);
      tick();
      daddr[2] = 32'h304; dstore[1] = 32'hDEAD_0002;
      wait_any("t4_b1");
      check("t4_b1_dwait", 32'(dwait), 32'h9);
      check("t4_b1_dload", dload[2], 32'hDEAD_0002);
      check("t4_b1_addr",  ramaddr, 32'h304);
      dREN = '0; ccwrite = '0; cctrans = '0;

      // ---------------- 5: S->M upgrade ----------------
      cctrans[3] = 1'b1; daddr[3] = 32'hC0;
      wait_any("t5_up");
      check("t5_dwait",  32'(dwait), 32'h7);
      check("t5_ccinv",  32'(ccinv), 32'h7);
      check("t5_snaddr0", ccsnoopaddr[0], 32'hC0);
      check("t5_snaddr3", ccsnoopaddr[3], 32'h0);
      check("t5_noram",  32'({ramREN, ramWEN}), 32'h0);
      tick();
      cctrans[3] = 1'b0;
      check("t5_idle_ccinv", 32'(ccinv), 32'h0);

      // ---------------- 6: reset in the middle of a C2C burst ----------------
      dREN[0] = 1'b1; daddr[0] = 32'h600; cctrans[1] = 1'b1; dstore[1] = 32'h5555_0001;
      wait_any("t6_b0");
      check("t6_b0_dload", dload[0], 32'h5555_0001);
      tick();
      nRST = 1'b0;
      #1;
      check("t6_rst_dwait", 32'(dwait), 32'hF);
      check("t6_rst_strobe", 32'({ramREN, ramWEN}), 32'h0);
      check("t6_rst_ccwait", 32'(ccwait), 32'h0);
      check("t6_rst_dload", dload[0], 32'h0);
      check("t6_rst_addr",  ramaddr, 32'h0);
      dREN = '0; cctrans = '0;
      @(negedge CLK);
      nRST = 1'b1;
      iREN[0] = 1'b1; iaddr[0] = 32'h500;
      iREN[3] = 1'b1; iaddr[3] = 32'h800;
      wait_any("t6_arb");
      check("t6_arb_iwait", 32'(iwait), 32'hE);
      check("t6_arb_iload", iload[0], mem(32'h500));
      iREN = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
